// File: rtl/dmem_arb_pkg.sv
// Shared constants and helpers for the two-master data-memory arbiter.
package dmem_arb_pkg;

    localparam logic [15:0] DEAD_WORD = 16'hDEAD;
    localparam logic        M0        = 1'b0;
    localparam logic        M1        = 1'b1;

    // RAM hit when the top winbits of a dbits-wide address are all zero.
    function automatic logic ram_hit(input logic [31:0] addr, input int dbits, input int winbits);
        logic hit;
        hit = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i < dbits && i >= dbits - winbits && addr[i]) begin
                hit = 1'b0;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester, read-return and memory-array signals of the data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int unsigned DBITS = 16,
    parameter int unsigned ABITS = 12
);
    logic             req0, req1, we0, we1, lock0, lock1;
    logic [DBITS-1:0] addr0, addr1, wdata0, wdata1;
    logic             gnt0, gnt1, rvalid0, rvalid1;
    logic [DBITS-1:0] rdata;
    logic [ABITS-1:0] mem_addr;
    logic [DBITS-1:0] mem_din, mem_dout;
    logic             mem_we;

    // Requesters plus the memory array, seen from outside the arbiter.
    modport master (
        output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, mem_dout,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, mem_addr, mem_din, mem_we
    );

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, mem_dout,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, mem_addr, mem_din, mem_we
    );
endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way picker: lock owner first, else round-robin against last winner.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       lock_owner,
    input  logic       lock_valid,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (lock_valid && req[lock_owner]) begin
            gnt[lock_owner] = 1'b1;
        end else if (&req) begin
            gnt[~last] = 1'b1;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter for the single data-memory port, one access per cycle.
// Optional grant locking is compiled in with `define DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
    parameter int unsigned DBITS    = 16,
    parameter int unsigned ABITS    = 12,
    parameter int unsigned WINBITS  = 3,
    parameter int unsigned LOCK_MAX = 8
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);
    import dmem_arb_pkg::*;

    logic             last_q, last_d;
    logic [1:0]       rd_pend_q, rd_pend_d;
    logic             hit_q, hit_d;
    logic [1:0]       req, req_eff, gnt;
    logic             sel, sel_we, sel_hit;
    logic [DBITS-1:0] sel_addr;
    logic             lock_owner, lock_valid;

    assign req        = {bus.req1, bus.req0};
    assign req_eff    = reset ? 2'b00 : req;
    assign lock_owner = last_q;

`ifdef DMEM_ARB_LOCK_EN
    localparam int unsigned CntW = $clog2(LOCK_MAX + 1);

    logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
    logic [1:0]      lock;

    assign lock = {bus.lock1, bus.lock0};

    // Lock holds while the owner keeps REQ+LOCK, unless its streak is spent and the other waits.
    assign lock_valid = (lock_cnt_q != '0) && req[last_q] && lock[last_q] &&
                        !((lock_cnt_q >= CntW'(LOCK_MAX)) && req[~last_q]);

    always_comb begin
        lock_cnt_d = '0;
        if ((|gnt) && lock[sel]) begin
            if (sel == last_q && lock_cnt_q != '0) begin
                lock_cnt_d = (lock_cnt_q >= CntW'(LOCK_MAX)) ? lock_cnt_q : lock_cnt_q + 1'b1;
            end else begin
                lock_cnt_d = CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) lock_cnt_q <= '0;
        else       lock_cnt_q <= lock_cnt_d;
    end
`else
    logic unused_lock;
    assign unused_lock = bus.lock0 ^ bus.lock1;
    assign lock_valid  = 1'b0;
`endif

    rr_pick2 u_pick (
        .req       (req_eff),
        .last      (last_q),
        .lock_owner(lock_owner),
        .lock_valid(lock_valid),
        .gnt       (gnt)
    );

    // When idle the memory side keeps following the last winner's request lines.
    assign sel      = (|gnt) ? gnt[1] : last_q;
    assign sel_addr = (sel == M1) ? bus.addr1 : bus.addr0;
    assign sel_we   = (sel == M1) ? bus.we1 : bus.we0;
    assign sel_hit  = ram_hit(32'(sel_addr), DBITS, WINBITS);

    assign bus.gnt0     = gnt[0];
    assign bus.gnt1     = gnt[1];
    assign bus.mem_addr = sel_addr[ABITS:1];
    assign bus.mem_din  = (sel == M1) ? bus.wdata1 : bus.wdata0;
    assign bus.mem_we   = (|gnt) && sel_we && sel_hit;

    always_comb begin
        last_d    = last_q;
        rd_pend_d = 2'b00;
        hit_d     = hit_q;
        if (|gnt) begin
            last_d = sel;
            if (!sel_we) begin
                rd_pend_d = gnt;
                hit_d     = sel_hit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q    <= M1;
            rd_pend_q <= 2'b00;
            hit_q     <= 1'b0;
        end else begin
            last_q    <= last_d;
            rd_pend_q <= rd_pend_d;
            hit_q     <= hit_d;
        end
    end

    assign bus.rvalid0 = rd_pend_q[0] && !reset;
    assign bus.rvalid1 = rd_pend_q[1] && !reset;
    assign bus.rdata   = ((|rd_pend_q) && !reset) ?
                         (hit_q ? bus.mem_dout : DBITS'(DEAD_WORD)) : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic vs a model.
module tb_dmem_arbiter;

    localparam int          LOCK_MAX = 3;
    localparam logic [15:0] DEAD     = 16'hDEAD;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.DBITS(16), .ABITS(12)) bus ();

    dmem_arbiter #(
        .DBITS   (16),
        .ABITS   (12),
        .WINBITS (3),
        .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Synchronous-read memory array with a preload port.
    logic [15:0] ram [4096];
    logic        pre_we;
    logic [11:0] pre_addr;
    logic [15:0] pre_data, ram_dout;
    always_ff @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
        ram_dout <= ram[bus.mem_addr];
    end
    assign bus.mem_dout = ram_dout;

    logic [1:0]  d_req, d_we, d_lock;
    logic [15:0] d_addr [2];
    logic [15:0] d_wdata [2];
    assign bus.req0 = d_req[0];   assign bus.req1 = d_req[1];
    assign bus.we0 = d_we[0];     assign bus.we1 = d_we[1];
    assign bus.lock0 = d_lock[0]; assign bus.lock1 = d_lock[1];
    assign bus.addr0 = d_addr[0]; assign bus.addr1 = d_addr[1];
    assign bus.wdata0 = d_wdata[0]; assign bus.wdata1 = d_wdata[1];

    // Reference model state.
    logic [15:0] ref_mem [4096];
    int          last_win, streak, win;
    logic [1:0]  pend;
    logic [15:0] pend_data;

    logic [1:0]  e_gnt, o_gnt, e_rv, o_rv;
    logic [15:0] e_rdata, o_rdata;
    logic        e_mwe, o_mwe;
    logic [11:0] e_maddr, o_maddr;
    int          n_tests = 0;
    int          n_fail = 0;

    // Inputs are set just after a posedge; sample and predict at the negedge.
    task automatic tick();
        logic hit;
        int   idx;
        @(negedge clk);
        o_gnt = {bus.gnt1, bus.gnt0};
        o_rv = {bus.rvalid1, bus.rvalid0};
        o_rdata = bus.rdata;
        o_mwe = bus.mem_we;
        o_maddr = bus.mem_addr;
        win = -1; hit = 1'b0; idx = 0;
        e_gnt = 2'b00; e_rv = 2'b00; e_rdata = 16'h0; e_mwe = 1'b0; e_maddr = 12'h0;
        if (!reset) begin
            e_rv = pend;
            e_rdata = (pend != 2'b00) ? pend_data : 16'h0;
            if (d_req == 2'b11) begin
                win = 1 - last_win;
`ifdef DMEM_ARB_LOCK_EN
                if (streak > 0 && d_lock[last_win] && streak < LOCK_MAX) win = last_win;
`endif
            end else if (d_req[0]) win = 0;
            else if (d_req[1]) win = 1;
            if (win >= 0) begin
                e_gnt = (win == 0) ? 2'b01 : 2'b10;
                hit = (d_addr[win][15:13] == 3'b000);
                idx = int'(d_addr[win][12:1]);
                e_mwe = d_we[win] && hit;
                e_maddr = d_addr[win][12:1];
            end
        end
        if (reset) begin
            last_win = 1; streak = 0; pend = 2'b00;
        end else if (win < 0) begin
            streak = 0; pend = 2'b00;
        end else begin
`ifdef DMEM_ARB_LOCK_EN
            if (d_lock[win])
                streak = (win == last_win && streak > 0) ?
                         ((streak < LOCK_MAX) ? streak + 1 : streak) : 1;
            else streak = 0;
`endif
            if (d_we[win]) begin
                if (hit) ref_mem[idx] = d_wdata[win];
                pend = 2'b00;
            end else begin
                pend = e_gnt;
                pend_data = hit ? ref_mem[idx] : DEAD;
            end
            last_win = win;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic preload();
        reset = 1'b1; d_req = 2'b00; d_we = 2'b00; d_lock = 2'b00;
        d_addr[0] = 16'h0; d_addr[1] = 16'h0; d_wdata[0] = 16'h0; d_wdata[1] = 16'h0;
        for (int i = 0; i < 64; i++) begin
            pre_we = 1'b1;
            pre_addr = 12'(i);
            pre_data = (i == 8) ? 16'h1234 : 16'($urandom);
            ref_mem[i] = pre_data;
            tick();
        end
        pre_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; d_req = 2'b11; d_we = 2'b00;
        tick();
        n_tests++; if (o_gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", o_gnt); end
        n_tests++; if (o_rv !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b want 00", o_rv); end
        n_tests++; if (o_rdata !== 16'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0000", o_rdata); end
        n_tests++; if (o_mwe !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", o_mwe); end
    endtask

    task automatic test_single_read();
        reset = 1'b0; d_req = 2'b01; d_we = 2'b00; d_addr[0] = 16'h0010;
        tick();
        n_tests++; if (o_gnt !== 2'b01) begin n_fail++; $display("FAIL rd_gnt: got %b want 01", o_gnt); end
        n_tests++; if (o_maddr !== 12'd8) begin n_fail++; $display("FAIL rd_maddr: got %h want 008", o_maddr); end
        d_req = 2'b00;
        tick();
        n_tests++; if (o_rv !== 2'b01) begin n_fail++; $display("FAIL rd_rvalid: got %b want 01", o_rv); end
        n_tests++; if (o_rdata !== 16'h1234) begin n_fail++; $display("FAIL rd_rdata: got %h want 1234", o_rdata); end
    endtask

    task automatic test_alternate();
        d_req = 2'b11; d_we = 2'b00;
        for (int i = 0; i < 6; i++) begin
            d_addr[0] = 16'($urandom_range(0, 127));
            d_addr[1] = 16'($urandom_range(0, 127));
            tick();
            // M0 won the previous contest, so M1 goes first.
            n_tests++; if (o_gnt !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL alt_gnt[%0d]: got %b want %b", i, o_gnt, (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            n_tests++; if (o_rv !== e_rv || (e_rv != 2'b00 && o_rdata !== e_rdata)) begin
                n_fail++; $display("FAIL alt_rd[%0d]: got %b/%h want %b/%h", i, o_rv, o_rdata, e_rv, e_rdata);
            end
        end
        d_req = 2'b00;
        tick();
        n_tests++; if (o_rv !== e_rv || o_rdata !== e_rdata) begin
            n_fail++; $display("FAIL alt_tail: got %b/%h want %b/%h", o_rv, o_rdata, e_rv, e_rdata);
        end
    endtask

    task automatic test_write_read();
        d_req = 2'b10; d_we = 2'b10; d_addr[1] = 16'h0020; d_wdata[1] = 16'hBEEF;
        tick();
        n_tests++; if (o_gnt !== 2'b10 || o_mwe !== 1'b1) begin
            n_fail++; $display("FAIL wr_hit: got gnt %b we %b want 10/1", o_gnt, o_mwe);
        end
        d_req = 2'b01; d_we = 2'b00; d_addr[0] = 16'h0020;
        tick();
        n_tests++; if (o_mwe !== 1'b0) begin n_fail++; $display("FAIL rd_after_wr_we: got %b want 0", o_mwe); end
        d_we = 2'b01; d_addr[0] = 16'hFFF8; d_wdata[0] = 16'h1111;
        tick();
        n_tests++; if (o_rv !== 2'b01 || o_rdata !== 16'hBEEF) begin
            n_fail++; $display("FAIL rd_after_wr: got %b/%h want 01/beef", o_rv, o_rdata);
        end
        n_tests++; if (o_gnt !== 2'b01 || o_mwe !== 1'b0) begin
            n_fail++; $display("FAIL miss_wr: got gnt %b we %b want 01/0", o_gnt, o_mwe);
        end
        d_we = 2'b00;
        tick();
        d_req = 2'b00;
        tick();
        n_tests++; if (o_rv !== 2'b01 || o_rdata !== DEAD) begin
            n_fail++; $display("FAIL miss_rd: got %b/%h want 01/dead", o_rv, o_rdata);
        end
    endtask

    task automatic test_reset_mid();
        d_req = 2'b01; d_we = 2'b00; d_addr[0] = 16'h0010;
        tick();
        reset = 1'b1; d_req = 2'b11;
        tick();
        n_tests++; if (o_rv !== 2'b00 || o_gnt !== 2'b00) begin
            n_fail++; $display("FAIL mid_reset: got rv %b gnt %b want 00/00", o_rv, o_gnt);
        end
        reset = 1'b0;
        tick();
        n_tests++; if (o_gnt !== 2'b01) begin n_fail++; $display("FAIL post_reset_gnt: got %b want 01", o_gnt); end
        d_req = 2'b00;
        tick();
    endtask

    task automatic test_lock();
        logic [1:0] seq [8];
`ifdef DMEM_ARB_LOCK_EN
        seq = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};
`else
        seq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`endif
        reset = 1'b1; d_req = 2'b00;
        tick();
        reset = 1'b0; d_req = 2'b11; d_lock = 2'b01; d_we = 2'b00;
        d_addr[0] = 16'h0004; d_addr[1] = 16'h0006;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_tests++; if (o_gnt !== seq[i] || o_gnt !== e_gnt) begin
                n_fail++; $display("FAIL lock_gnt[%0d]: got %b want %b", i, o_gnt, seq[i]);
            end
        end
        d_req = 2'b00; d_lock = 2'b00;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            d_req = 2'($urandom); d_we = 2'($urandom); d_lock = 2'($urandom);
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 3) == 0) d_addr[k] = 16'hE000 | 16'($urandom);
                else d_addr[k] = 16'($urandom_range(0, 127));
                d_wdata[k] = 16'($urandom);
            end
            tick();
            n_tests++; if (o_gnt !== e_gnt || (o_gnt & ~d_req) != 2'b00) begin
                n_fail++; $display("FAIL rnd_gnt[%0d]: got %b want %b req %b", i, o_gnt, e_gnt, d_req);
            end
            n_tests++; if (o_mwe !== e_mwe) begin
                n_fail++; $display("FAIL rnd_mem_we[%0d]: got %b want %b", i, o_mwe, e_mwe);
            end
            n_tests++; if (o_rv !== e_rv || (e_rv != 2'b00 && o_rdata !== e_rdata)) begin
                n_fail++; $display("FAIL rnd_rd[%0d]: got %b/%h want %b/%h", i, o_rv, o_rdata, e_rv, e_rdata);
            end
            if (e_gnt != 2'b00) begin
                n_tests++; if (o_maddr !== e_maddr) begin
                    n_fail++; $display("FAIL rnd_maddr[%0d]: got %h want %h", i, o_maddr, e_maddr);
                end
            end
        end
    endtask

    initial begin
        pre_we = 1'b0; pre_addr = 12'h0; pre_data = 16'h0;
        last_win = 1; streak = 0; pend = 2'b00; pend_data = 16'h0;
        preload();
        test_reset();
        test_single_read();
        test_alternate();
        test_write_read();
        test_reset_mid();
        test_lock();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
